// File: rtl/cv32e40p_regfile_pkg.sv
`default_nettype none
// ============================================================================
// cv32e40p_regfile_pkg : register-file sizing constants and address mapping
// Revision 1.0
// ============================================================================
package cv32e40p_regfile_pkg;

   localparam int NUM_INT_REGS = 32;
   localparam int NUM_FP_REGS  = 32;
   localparam int RF_ADDR_W    = 6;
   localparam int RF_IDX_W     = 6;

   function automatic logic rf_has_fp(input int fpu, input int zfinx);
      return (fpu != 0) && (zfinx == 0);
   endfunction

   // Without an FP bank the bank-select MSB is dropped so f-registers alias x-registers.
   function automatic logic [RF_IDX_W-1:0] rf_index(input logic [RF_ADDR_W-1:0] addr,
                                                    input logic               has_fp);
      return has_fp ? addr : {1'b0, addr[RF_ADDR_W-2:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// cv32e40p_regfile_scoreboard : busy bit per register for in-flight multi-cycle writes
// Revision 1.0
// ============================================================================
module cv32e40p_regfile_scoreboard
   import cv32e40p_regfile_pkg::*;
#(
   parameter int NUM_REGS = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REGS-1:0] wr_dec_i,
   input  logic [NUM_REGS-1:0] rsv_dec_i,
   input  logic                flush_i,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                busy_any_o
);

   logic [NUM_REGS-1:0] busy;

   // A reservation wins over a same-cycle clear: it belongs to a younger instruction.
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~wr_dec_i) | rsv_dec_i;
      end
   end

   assign busy_o     = busy;
   assign busy_any_o = |busy;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_regfile_mp.sv
`default_nettype none
// ============================================================================
// cv32e40p_regfile_mp : multi-ported flop register file with bypass and busy scoreboard
// Revision 1.0
// ============================================================================
module cv32e40p_regfile_mp
   import cv32e40p_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RPORTS = 3,
   parameter int NUM_WPORTS = 2,
   parameter int FPU        = 1,
   parameter int ZFINX      = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] raddr_i     [NUM_RPORTS],
   output logic [DATA_WIDTH-1:0] rdata_o     [NUM_RPORTS],
   output logic [NUM_RPORTS-1:0] rbusy_o,
   input  logic [ADDR_WIDTH-1:0] waddr_i     [NUM_WPORTS],
   input  logic [DATA_WIDTH-1:0] wdata_i     [NUM_WPORTS],
   input  logic [NUM_WPORTS-1:0] we_i,
   input  logic                  rsv_valid_i,
   input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
   input  logic                  flush_i,
   output logic                  busy_any_o
);

   localparam logic HAS_FP   = rf_has_fp(FPU, ZFINX);
   localparam int   NUM_REGS = HAS_FP ? (NUM_INT_REGS + NUM_FP_REGS) : NUM_INT_REGS;

   logic [RF_IDX_W-1:0]   widx    [NUM_WPORTS];
   logic [RF_IDX_W-1:0]   ridx    [NUM_RPORTS];
   logic [RF_IDX_W-1:0]   rsv_idx;
   logic [NUM_REGS-1:0]   wr_dec;
   logic [NUM_REGS-1:0]   rsv_dec;
   logic [DATA_WIDTH-1:0] wr_data [NUM_REGS];
   logic [DATA_WIDTH-1:0] mem     [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;

   always_comb begin
      for (int q = 0; q < NUM_WPORTS; q++) begin
         widx[q] = rf_index(waddr_i[q], HAS_FP);
      end
      for (int p = 0; p < NUM_RPORTS; p++) begin
         ridx[p] = rf_index(raddr_i[p], HAS_FP);
      end
      rsv_idx = rf_index(rsv_addr_i, HAS_FP);
   end

   // Ports are scanned in ascending order so the highest-index writer lands last.
   always_comb begin
      wr_dec  = '0;
      rsv_dec = '0;
      wr_data = '{default: '0};
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int q = 0; q < NUM_WPORTS; q++) begin
            if (we_i[q] && (widx[q] == RF_IDX_W'(r))) begin
               wr_dec[r]  = 1'b1;
               wr_data[r] = wdata_i[q];
            end
         end
         rsv_dec[r] = rsv_valid_i && (rsv_idx == RF_IDX_W'(r));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_dec[r]) begin
               mem[r] <= wr_data[r];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RPORTS; p++) begin
         rdata_o[p] = '0;
         rbusy_o[p] = 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            if (ridx[p] == RF_IDX_W'(r)) begin
               rdata_o[p] = mem[r];
               rbusy_o[p] = busy[r];
            end
         end
         if ((BYPASS != 0) && rst_n) begin
            for (int q = 0; q < NUM_WPORTS; q++) begin
               if (we_i[q] && (widx[q] == ridx[p])) begin
                  rdata_o[p] = wdata_i[q];
               end
            end
         end
         if (ridx[p] == '0) begin
            rdata_o[p] = '0;
            rbusy_o[p] = 1'b0;
         end
      end
   end

   cv32e40p_regfile_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_dec_i   (wr_dec),
      .rsv_dec_i  (rsv_dec),
      .flush_i    (flush_i),
      .busy_o     (busy),
      .busy_any_o (busy_any_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_cv32e40p_regfile_mp : three configurations (bypass, no bypass, zfinx) vs. array model
// Revision 1.0
// ============================================================================
module tb_cv32e40p_regfile_mp;

   localparam int NR = 3;
   localparam int NW = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  raddr [NR];
   logic [5:0]  waddr [NW];
   logic [31:0] wdata [NW];
   logic [NW-1:0] we;
   logic        rsv_valid;
   logic [5:0]  rsv_addr;
   logic        flush;

   logic [31:0] rd0 [NR];
   logic [31:0] rd1 [NR];
   logic [31:0] rd2 [NR];
   logic [NR-1:0] rb0, rb1, rb2;
   logic        ba0, ba1, ba2;

   int compared = 0;
   int mismatched = 0;

   // Model state per configuration: 0 = FP bank + bypass, 1 = FP bank no bypass, 2 = zfinx + bypass
   logic [31:0] m_mem  [3][64];
   logic        m_busy [3][64];

   always #5 clk = ~clk;

   cv32e40p_regfile_mp #(.BYPASS(1), .ZFINX(0)) dut (
      .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rd0), .rbusy_o(rb0),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_any_o(ba0));

   cv32e40p_regfile_mp #(.BYPASS(0), .ZFINX(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rd1), .rbusy_o(rb1),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_any_o(ba1));

   cv32e40p_regfile_mp #(.BYPASS(1), .ZFINX(1)) dut_zx (
      .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rd2), .rbusy_o(rb2),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
      .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_any_o(ba2));

   function automatic int midx(input int c, input logic [5:0] a);
      return (c == 2) ? int'(a[4:0]) : int'(a);
   endfunction

   function automatic logic [31:0] exp_rd(input int c, input int p);
      int i;
      logic [31:0] v;
      i = midx(c, raddr[p]);
      if (i == 0) return 32'h0;
      v = m_mem[c][i];
      if ((c != 1) && rst_n) begin
         for (int q = 0; q < NW; q++) begin
            if (we[q] && (midx(c, waddr[q]) == i)) v = wdata[q];
         end
      end
      return v;
   endfunction

   function automatic logic exp_rb(input int c, input int p);
      int i;
      i = midx(c, raddr[p]);
      return (i == 0) ? 1'b0 : m_busy[c][i];
   endfunction

   function automatic logic exp_ba(input int c);
      logic any;
      any = 1'b0;
      for (int i = 0; i < 64; i++) any = any | m_busy[c][i];
      return any;
   endfunction

   function automatic logic [31:0] get_rd(input int c, input int p);
      case (c)
         0:       return rd0[p];
         1:       return rd1[p];
         default: return rd2[p];
      endcase
   endfunction

   function automatic logic get_rb(input int c, input int p);
      case (c)
         0:       return rb0[p];
         1:       return rb1[p];
         default: return rb2[p];
      endcase
   endfunction

   function automatic logic get_ba(input int c);
      case (c)
         0:       return ba0;
         1:       return ba1;
         default: return ba2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < NR; p++) begin
            chk($sformatf("cfg%0d rdata[%0d] addr=%h", c, p, raddr[p]), get_rd(c, p), exp_rd(c, p));
            chk($sformatf("cfg%0d rbusy[%0d] addr=%h", c, p, raddr[p]),
                32'(get_rb(c, p)), 32'(exp_rb(c, p)));
         end
         chk($sformatf("cfg%0d busy_any", c), 32'(get_ba(c)), 32'(exp_ba(c)));
      end
   endtask

   // Applies the architectural effect of one clock edge to the model.
   task automatic model_edge();
      for (int c = 0; c < 3; c++) begin
         if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
               m_mem[c][i]  = 32'h0;
               m_busy[c][i] = 1'b0;
            end
         end else begin
            for (int q = 0; q < NW; q++) begin
               if (we[q] && midx(c, waddr[q]) != 0) begin
                  m_mem[c][midx(c, waddr[q])]  = wdata[q];
                  m_busy[c][midx(c, waddr[q])] = 1'b0;
               end
            end
            if (rsv_valid && midx(c, rsv_addr) != 0) m_busy[c][midx(c, rsv_addr)] = 1'b1;
            if (flush) for (int i = 0; i < 64; i++) m_busy[c][i] = 1'b0;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we        = '0;
      rsv_valid = 1'b0;
      flush     = 1'b0;
   endtask

   function automatic logic [5:0] rand_addr();
      if ($urandom_range(0, 1) != 0) return 6'($urandom_range(0, 63));
      return {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
   endfunction

   initial begin
      rst_n = 1'b0;
      idle();
      rsv_addr = '0;
      for (int p = 0; p < NR; p++) raddr[p] = '0;
      for (int q = 0; q < NW; q++) begin
         waddr[q] = '0;
         wdata[q] = '0;
      end
      for (int c = 0; c < 3; c++) for (int i = 0; i < 64; i++) begin
         m_mem[c][i]  = 32'h0;
         m_busy[c][i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sample();
      chk("reset busy_any", 32'(ba0), 32'h0);
      edge_step();

      // Reset clears a previously written register
      we = 2'b01; waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF;
      sample(); edge_step();
      idle(); raddr[0] = 6'd5;
      sample(); chk("x5 written", rd0[0], 32'hDEADBEEF); edge_step();
      rst_n = 1'b0;
      sample(); edge_step();
      rst_n = 1'b1;
      sample();
      chk("x5 after reset", rd0[0], 32'h0);
      chk("busy_any after reset", 32'(ba0), 32'h0);
      edge_step();

      // x0 is hard zero, f0 is writable, x0 cannot be reserved
      we = 2'b11; waddr[0] = 6'h00; wdata[0] = 32'h1234; waddr[1] = 6'h20; wdata[1] = 32'h5678;
      sample(); edge_step();
      idle(); raddr[0] = 6'h00; raddr[1] = 6'h20; rsv_valid = 1'b1; rsv_addr = 6'h00;
      sample();
      chk("x0 read", rd0[0], 32'h0);
      chk("f0 read", rd0[1], 32'h5678);
      edge_step();
      idle();
      sample(); chk("x0 rbusy", 32'(rb0[0]), 32'h0); edge_step();

      // Write collision and bypass
      raddr[0] = 6'd7; we = 2'b11; waddr[0] = 6'd7; wdata[0] = 32'hA; waddr[1] = 6'd7; wdata[1] = 32'hB;
      sample();
      chk("x7 bypass collision", rd0[0], 32'hB);
      chk("x7 no-bypass old value", rd1[0], 32'h0);
      edge_step();
      idle();
      sample();
      chk("x7 stored collision", rd0[0], 32'hB);
      chk("x7 stored no-bypass", rd1[0], 32'hB);
      edge_step();

      // Reserve x9, three idle cycles, then a clearing write
      raddr[0] = 6'd9; rsv_valid = 1'b1; rsv_addr = 6'd9;
      sample(); chk("x9 rbusy same cycle", 32'(rb0[0]), 32'h0); edge_step();
      idle();
      for (int k = 1; k <= 3; k++) begin
         sample(); chk($sformatf("x9 rbusy cycle %0d", k), 32'(rb0[0]), 32'h1); edge_step();
      end
      we = 2'b01; waddr[0] = 6'd9; wdata[0] = 32'h42;
      sample();
      chk("x9 rbusy cycle 4", 32'(rb0[0]), 32'h1);
      chk("x9 bypass 0x42", rd0[0], 32'h42);
      edge_step();
      idle();
      sample();
      chk("x9 rbusy after write", 32'(rb0[0]), 32'h0);
      chk("x9 data", rd0[0], 32'h42);
      edge_step();

      // Reserve and write the same register together
      rsv_valid = 1'b1; rsv_addr = 6'd9;
      sample(); edge_step();
      we = 2'b01; waddr[0] = 6'd9; wdata[0] = 32'h1;
      sample(); edge_step();
      idle();
      sample();
      chk("x9 stays busy", 32'(rb0[0]), 32'h1);
      chk("x9 reads 0x1", rd0[0], 32'h1);
      edge_step();

      // Flush clears every reservation
      rsv_valid = 1'b1; rsv_addr = 6'd3;
      sample(); edge_step();
      rsv_addr = 6'h24;
      sample(); edge_step();
      idle(); flush = 1'b1;
      sample(); chk("busy_any before flush", 32'(ba0), 32'h1); edge_step();
      idle();
      sample(); chk("busy_any after flush", 32'(ba0), 32'h0); edge_step();

      // ZFINX aliases f3 onto x3
      we = 2'b01; waddr[0] = 6'h23; wdata[0] = 32'h77;
      sample(); edge_step();
      idle(); raddr[0] = 6'd3;
      sample();
      chk("zfinx x3 reads 0x77", rd2[0], 32'h77);
      chk("fp bank x3 untouched", rd0[0], 32'h0);
      edge_step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         we        = NW'($urandom_range(0, 3));
         for (int q = 0; q < NW; q++) begin
            waddr[q] = rand_addr();
            wdata[q] = $urandom;
         end
         for (int p = 0; p < NR; p++) raddr[p] = rand_addr();
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_addr  = rand_addr();
         flush     = ($urandom_range(0, 19) == 0);
         sample();
         edge_step();
      end
      rst_n = 1'b1;
      idle();
      sample();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cv32e40p_regfile_mp.md
# cv32e40p_regfile_mp

Flip-flop-based, multi-ported integer/FP register file for the ID stage. It generalises the fixed 3-read/2-write file to a parametrised number of read and write ports. It adds an optional write-to-read bypass and a per-register busy scoreboard, which tracks writes still pending from multi-cycle producers (LSU, FPU). It sits between the decoder (read and reserve requests) and the WB/APU writeback paths (write ports).

## Interface
- `ADDR_WIDTH`, 6: register address width. The MSB selects the FP bank; the lower 5 bits select the register.
- `DATA_WIDTH`, 32: register width.
- `NUM_RPORTS`, 3: number of read ports, 1..4.
- `NUM_WPORTS`, 2: number of write ports, 1..4.
- `FPU`, 1: the FP bank exists.
- `ZFINX`, 0: when 1, the FP bank is removed and FP operands use the integer bank.
- `BYPASS`, 1: when 1, a read returns the same-cycle write data.

Clock/reset: one clock; reset is synchronous and active-low.

- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `raddr_i` in [NUM_RPORTS][ADDR_WIDTH]: read addresses.
- `rdata_o` out [NUM_RPORTS][DATA_WIDTH]: read data.
- `rbusy_o` out [NUM_RPORTS]: the addressed register has a pending reservation.
- `waddr_i` in [NUM_WPORTS][ADDR_WIDTH]: write addresses.
- `wdata_i` in [NUM_WPORTS][DATA_WIDTH]: write data.
- `we_i` in [NUM_WPORTS]: write enables.
- `rsv_valid_i` in 1: reserve the register at `rsv_addr_i`, marking it busy.
- `rsv_addr_i` in ADDR_WIDTH: address to reserve.
- `flush_i` in 1: clear all busy bits.
- `busy_any_o` out 1: OR of all busy bits.

## Operation
- **Banks**
  - Integer bank: 32 entries; x0 reads 0 and ignores writes and reservations.
  - FP bank: 32 entries, present only when FPU=1 and ZFINX=0; f0 is an ordinary writable register.
  - Without the FP bank, the address MSB is ignored and all accesses map to the integer bank.
- **Reads**
  - Combinational from the storage array.
  - With BYPASS=1, if any enabled write port targets the read address this cycle, `rdata_o` returns that port's `wdata_i`, using the winner under the collision rule below.
  - An x0 read is always 0.
- **Writes**
  - Each enabled write port updates its register at the clock edge.
  - When several ports target the same register, the highest-index port wins.
- **Scoreboard**
  - One busy bit per writable register.
  - Next-state priority, highest first:
    1. reset or `flush_i`: all bits 0.
    2. `rsv_valid_i` to address A: busy[A] = 1. This applies even if A is written in the same cycle, because the reservation belongs to a younger instruction.
    3. Any enabled write to address A: busy[A] = 0.
    4. Otherwise: hold.
  - `rbusy_o[p]` = busy[raddr_i[p]], combinational, with no bypass of a same-cycle clear or set.
  - `rbusy_o` for x0 is always 0.
- **Reset**
  - All registers are 0 and all busy bits are 0.
  - `rdata_o` = 0, `rbusy_o` = 0, `busy_any_o` = 0.
  - While `rst_n`=0, writes and reservations are ignored.

## Timing
- Read latency is 0 cycles, combinational from `raddr_i`.
- A write on edge N is visible to plain reads from cycle N+1.
- With BYPASS=1, the write is also visible in cycle N, combinationally.
- A reservation on edge N sets `rbusy_o` from cycle N+1; a clearing write behaves the same way.
- `flush_i` takes effect at the next edge. It does not block same-cycle writes to the data array.
- Reset asserted mid-operation clears data and scoreboard at the next edge. There is no partial state.

## Structure
- Package `cv32e40p_regfile_pkg` holds:
  - `NUM_INT_REGS` = 32 and `NUM_FP_REGS` = 32.
  - Function `rf_has_fp(FPU, ZFINX)`.
  - Function `rf_index(addr)`, which maps a register address to an array index.
- Sub-module `cv32e40p_regfile_scoreboard` holds the busy-bit vector. Its inputs are the write-port decode, reserve, and flush; its outputs are the busy vector and `busy_any_o`.
- Storage is a flop array. No latches or clock-gate cells are used.

## Test plan
- **Reset:** write x5 = 0xDEADBEEF, then pulse `rst_n`=0 for 1 cycle. Required: reading x5 returns 0 and `busy_any_o` = 0.
- **x0 and f0:** write x0 = 0x1234 and f0 (addr 0x20) = 0x5678. Required: x0 reads 0; f0 reads 0x5678; reserving x0 leaves `rbusy_o` = 0.
- **Collision and bypass (BYPASS=1):** port0 and port1 both write x7, with 0xA and 0xB. Required: a same-cycle read of x7 returns 0xB, and the next cycle also returns 0xB. With BYPASS=0, the same-cycle read returns the old value.
- **Reserve/clear:** reserve x9, then 3 idle cycles, then write x9 = 0x42. Required: `rbusy_o` for x9 is 1 for cycles 1–4 and 0 after the write edge; the data reads 0x42.
- **Simultaneous reserve and write:** x9 is busy; in the same cycle, write x9 = 0x1 and reserve x9. Required: x9 stays busy and reads 0x1.
- **Flush and ZFINX:**
  - Reserve x3 and f4, then `flush_i`. Required: `busy_any_o` = 0 next cycle.
  - With ZFINX=1, write addr 0x23 = 0x77. Required: x3 reads 0x77.
